// File: rtl/corelet_inst_pkg.sv
// Shared instruction-word layout for the corelet: bit positions, the idle word
// and the sequencer state encoding, reused by core decode and benches.
package corelet_inst_pkg;

  localparam int INST_W      = 35;
  localparam int BIT_MODE    = 34;
  localparam int BIT_ACC     = 33;
  localparam int BIT_CEN_P   = 32;
  localparam int BIT_WEN_P   = 31;
  localparam int A_PMEM_LSB  = 20;
  localparam int A_PMEM_W    = 11;
  localparam int BIT_CEN_X   = 19;
  localparam int BIT_WEN_X   = 18;
  localparam int A_XMEM_LSB  = 7;
  localparam int A_XMEM_W    = 11;
  localparam int BIT_OFIFO_RD = 6;
  localparam int BIT_IFIFO_RD = 5;
  localparam int BIT_IFIFO_WR = 4;
  localparam int BIT_L0_RD   = 3;
  localparam int BIT_L0_WR   = 2;
  localparam int BIT_EXECUTE = 1;
  localparam int BIT_LOAD    = 0;

  // Memory enables/write-enables deasserted (active low), everything else 0.
  localparam logic [INST_W-1:0] IDLE_WORD = 35'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WXMEM  = 4'd1,
    S_WLOAD  = 4'd2,
    S_WFLUSH = 4'd3,
    S_AXMEM  = 4'd4,
    S_EXEC   = 4'd5,
    S_DRAIN  = 4'd6,
    S_PWR    = 4'd7,
    S_DONE   = 4'd8
  } seq_state_e;

endpackage

// File: rtl/corelet_seq_if.sv
// Host-facing control bundle of the instruction sequencer.
interface corelet_seq_if #(
  parameter int xaw = 11,
  parameter int paw = 11
);
  // start is a level request sampled only while idle (no ready handshake:
  // busy low means the next sampled start is accepted); done is a one-cycle
  // completion pulse and needs no acknowledge.
  logic           start;
  logic           mode;
  logic [xaw-1:0] w_base;
  logic [xaw-1:0] a_base;
  logic [paw-1:0] p_base;
  logic [34:0]    inst;
  logic           busy;
  logic           done;

  modport master (output start, mode, w_base, a_base, p_base,
                  input  inst, busy, done);
  modport slave  (input  start, mode, w_base, a_base, p_base,
                  output inst, busy, done);
endinterface

// File: rtl/seq_counter.sv
// Loadable up-counter that flags the last cycle of a per-state cycle budget.
module seq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clear ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == limit - W'(1));

endmodule

// File: rtl/corelet_seq.sv
// Kernel-position pass sequencer: fetch/load weights, stream activations,
// drain OFIFO into pmem, then pulse done.
module corelet_seq
  import corelet_inst_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_nij = 36,
  parameter int xaw     = 11,
  parameter int paw     = 11
) (
  input  logic        clk,
  input  logic        reset,
  corelet_seq_if.slave bus,
  output seq_state_e  dbg_state
);

  localparam int CW = 16;

  seq_state_e     state_q, state_d;
  logic           mode_q, mode_d;
  logic [xaw-1:0] w_base_q, w_base_d, a_base_q, a_base_d;
  logic [paw-1:0] p_base_q, p_base_d;
  logic [CW-1:0]  cnt, limit;
  logic           cnt_last, cnt_clear;

  // Counter restarts on every state entry; IDLE keeps it parked at zero.
  assign cnt_clear = (state_q == S_IDLE) || cnt_last;

  seq_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst   (reset),
    .clear (cnt_clear),
    .limit (limit),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  always_comb begin
    limit = CW'(1);
    case (state_q)
      S_WXMEM:  limit = CW'(col + 1);
      S_WLOAD:  limit = CW'(col);
      S_WFLUSH: limit = CW'(row + col);
      S_AXMEM:  limit = CW'(len_nij + 1);
      S_EXEC:   limit = CW'(len_nij);
      S_DRAIN:  limit = CW'(row + col);
      S_PWR:    limit = CW'(len_nij);
      default:  limit = CW'(1);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
      p_base_q <= p_base_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    p_base_d = p_base_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d  = S_WXMEM;
        mode_d   = bus.mode;
        w_base_d = bus.w_base;
        a_base_d = bus.a_base;
        p_base_d = bus.p_base;
      end
      S_WXMEM:  if (cnt_last) state_d = S_WLOAD;
      S_WLOAD:  if (cnt_last) state_d = S_WFLUSH;
      S_WFLUSH: if (cnt_last) state_d = S_AXMEM;
      S_AXMEM:  if (cnt_last) state_d = S_EXEC;
      S_EXEC:   if (cnt_last) state_d = S_DRAIN;
      S_DRAIN:  if (cnt_last) state_d = S_PWR;
      S_PWR:    if (cnt_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Fetch phases read xmem for the first N cycles; the strobe trails by one
  // cycle to line up with the SRAM read latency.
  always_comb begin
    bus.inst = IDLE_WORD;
    case (state_q)
      S_WXMEM: begin
        if (cnt < CW'(col)) begin
          bus.inst[BIT_CEN_X] = 1'b0;
          bus.inst[A_XMEM_LSB +: xaw] = w_base_q + xaw'(cnt);
        end
        if (cnt != '0) begin
          if (mode_q) bus.inst[BIT_IFIFO_WR] = 1'b1;
          else        bus.inst[BIT_L0_WR]    = 1'b1;
        end
      end
      S_WLOAD: begin
        bus.inst[BIT_LOAD] = 1'b1;
        if (mode_q) bus.inst[BIT_IFIFO_RD] = 1'b1;
        else        bus.inst[BIT_L0_RD]    = 1'b1;
      end
      S_AXMEM: begin
        if (cnt < CW'(len_nij)) begin
          bus.inst[BIT_CEN_X] = 1'b0;
          bus.inst[A_XMEM_LSB +: xaw] = a_base_q + xaw'(cnt);
        end
        if (cnt != '0) bus.inst[BIT_L0_WR] = 1'b1;
      end
      S_EXEC: begin
        bus.inst[BIT_EXECUTE] = 1'b1;
        bus.inst[BIT_L0_RD]   = 1'b1;
      end
      S_PWR: begin
        bus.inst[BIT_OFIFO_RD] = 1'b1;
        bus.inst[BIT_CEN_P]    = 1'b0;
        bus.inst[BIT_WEN_P]    = 1'b0;
        bus.inst[A_PMEM_LSB +: paw] = p_base_q + paw'(cnt);
      end
      default: ;
    endcase
    if (state_q != S_IDLE) bus.inst[BIT_MODE] = mode_q;
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_corelet_seq.sv
// Directed bench for corelet_seq: WS/OS passes, pmem address wrap,
// start-while-busy, back-to-back start and asynchronous reset mid-pass.
module tb_corelet_seq;
  import corelet_inst_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  seq_state_e dbg_state;
  int         errors = 0;
  int         checks = 0;

  corelet_seq_if #(.xaw(11), .paw(11)) bus ();

  corelet_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected word for cycle c of a pass (cycle 1 = first WXMEM cycle),
  // taken from the phase timetable for the default 8x8 array, 36 vectors.
  function automatic logic [34:0] exp_inst(input int c, input logic m,
                                           input logic [10:0] w, input logic [10:0] a,
                                           input logic [10:0] p);
    logic [34:0] x;
    logic [10:0] k;
    x = IDLE_WORD;
    if (c >= 1 && c <= 159) x[BIT_MODE] = m;
    if (c >= 1 && c <= 9) begin
      k = 11'(c - 1);
      if (c <= 8) begin x[BIT_CEN_X] = 1'b0; x[A_XMEM_LSB +: 11] = w + k; end
      if (c >= 2) begin
        if (m) x[BIT_IFIFO_WR] = 1'b1; else x[BIT_L0_WR] = 1'b1;
      end
    end
    if (c >= 10 && c <= 17) begin
      x[BIT_LOAD] = 1'b1;
      if (m) x[BIT_IFIFO_RD] = 1'b1; else x[BIT_L0_RD] = 1'b1;
    end
    if (c >= 34 && c <= 70) begin
      k = 11'(c - 34);
      if (c <= 69) begin x[BIT_CEN_X] = 1'b0; x[A_XMEM_LSB +: 11] = a + k; end
      if (c >= 35) x[BIT_L0_WR] = 1'b1;
    end
    if (c >= 71 && c <= 106) begin x[BIT_EXECUTE] = 1'b1; x[BIT_L0_RD] = 1'b1; end
    if (c >= 123 && c <= 158) begin
      k = 11'(c - 123);
      x[BIT_OFIFO_RD] = 1'b1;
      x[BIT_CEN_P]    = 1'b0;
      x[BIT_WEN_P]    = 1'b0;
      x[A_PMEM_LSB +: 11] = p + k;
    end
    return x;
  endfunction

  // Runs one full pass and checks every cycle through the return to IDLE.
  // Inputs are scrambled after acceptance to prove they were latched.
  task automatic run_pass(input string tag, input logic m, input logic [10:0] w,
                          input logic [10:0] a, input logic [10:0] p,
                          input int pulse_c, input bit hold);
    bus.mode = m; bus.w_base = w; bus.a_base = a; bus.p_base = p;
    bus.start = 1'b1;
    step();
    bus.mode = ~m; bus.w_base = ~w; bus.a_base = ~a; bus.p_base = ~p;
    for (int c = 1; c <= 159; c++) begin
      if (c == pulse_c) bus.start = 1'b1;
      else if (!hold)   bus.start = 1'b0;
      chk($sformatf("%s_inst_c%0d", tag, c), bus.inst, exp_inst(c, m, w, a, p));
      chk($sformatf("%s_busy_c%0d", tag, c), 35'(bus.busy), 35'(1));
      chk($sformatf("%s_done_c%0d", tag, c), 35'(bus.done), 35'(c == 159));
      if (m == 1'b0 && w == 11'd0 && c == 2)
        chk($sformatf("%s_c2_word", tag), bus.inst, 35'h1_8004_0084);
      if (m == 1'b0 && p == 11'd0 && c == 123)
        chk($sformatf("%s_c123_word", tag), bus.inst, 35'h0_000C_0040);
      step();
    end
    chk($sformatf("%s_idle_inst", tag), bus.inst, IDLE_WORD);
    chk($sformatf("%s_idle_busy", tag), 35'(bus.busy), 35'(0));
    chk($sformatf("%s_idle_done", tag), 35'(bus.done), 35'(0));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0;
    bus.w_base = '0; bus.a_base = '0; bus.p_base = '0;
    step(); step();
    chk("rst_inst", bus.inst, IDLE_WORD);
    chk("rst_busy", 35'(bus.busy), 35'(0));
    chk("rst_done", 35'(bus.done), 35'(0));
    chk("rst_state", 35'(dbg_state), 35'(S_IDLE));
    reset = 1'b0;
    step(); step();
    chk("post_rst_inst", bus.inst, IDLE_WORD);
    chk("post_rst_busy", 35'(bus.busy), 35'(0));

    run_pass("ws", 1'b0, 11'd0, 11'd8, 11'd0, 0, 1'b0);
    step();
    run_pass("os", 1'b1, 11'h010, 11'h040, 11'h100, 50, 1'b0);
    step();
    run_pass("wrap", 1'b0, 11'h7FC, 11'h7F0, 11'h7F0, 0, 1'b0);
    step();

    // start held high: after the cycle-160 IDLE, cycle 161 is the new WXMEM.
    run_pass("hold", 1'b1, 11'h020, 11'h030, 11'h050, 0, 1'b1);
    bus.mode = 1'b0; bus.w_base = 11'h123;
    step();
    chk("hold_restart_busy", 35'(bus.busy), 35'(1));
    chk("hold_restart_inst", bus.inst, exp_inst(1, 1'b0, 11'h123, 11'h0, 11'h0));
    bus.start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Asynchronous reset in the middle of EXEC (cycle 80).
    bus.mode = 1'b1; bus.w_base = 11'd0; bus.a_base = 11'd8; bus.p_base = 11'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c < 80; c++) step();
    chk("mid_exec_state", 35'(dbg_state), 35'(S_EXEC));
    chk("mid_exec_inst", bus.inst, exp_inst(80, 1'b1, 11'd0, 11'd8, 11'd0));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_inst", bus.inst, IDLE_WORD);
    chk("async_rst_busy", 35'(bus.busy), 35'(0));
    chk("async_rst_done", 35'(bus.done), 35'(0));
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rst_hold_inst_%0d", c), bus.inst, IDLE_WORD);
      chk($sformatf("rst_hold_busy_%0d", c), 35'(bus.busy), 35'(0));
      chk($sformatf("rst_hold_state_%0d", c), 35'(dbg_state), 35'(S_IDLE));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/corelet_seq.md
# corelet_seq

Instruction sequencer that drives the 35-bit `inst` word consumed by the corelet, plus the activation/weight SRAM (xmem) and psum SRAM (pmem) control fields carried in the same word. On `start` it runs one complete kernel-position (kij) pass:
- fetch weights into L0 or IFIFO;
- load them into the MAC array;
- stream activations and execute;
- drain the OFIFO into pmem.

It then pulses `done`. It sits between the top-level testbench/host and `core`, replacing hand-written instruction streams.

## Interface
- `row`, 8: MAC array rows (L0 width in lanes).
- `col`, 8: MAC array columns; number of weight vectors per pass.
- `len_nij`, 36: activation vectors per pass.
- `xaw`, 11: xmem address width.
- `paw`, 11: pmem address width.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: begin a pass; sampled only in IDLE.
- `mode`, in, 1: 0 = WS, 1 = OS; latched on accepted `start`.
- `w_base`, in, `xaw`: xmem address of the first weight vector; latched on `start`.
- `a_base`, in, `xaw`: xmem address of the first activation vector; latched on `start`.
- `p_base`, in, `paw`: pmem address of the first psum row; latched on `start`.
- `inst`, out, 35: corelet/memory instruction word.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse in the DONE state.

## Operation
inst bit map:
- [34] mode
- [33] acc (held 0)
- [32] CEN_pmem (active low)
- [31] WEN_pmem (active low)
- [30:20] A_pmem
- [19] CEN_xmem (active low)
- [18] WEN_xmem (active low)
- [17:7] A_xmem
- [6] ofifo_rd
- [5] ififo_rd
- [4] ififo_wr
- [3] l0_rd
- [2] l0_wr
- [1] execute
- [0] load

Idle word: CEN/WEN bits = 1, all other bits 0, i.e. 35'h1_800C_0000. Unused A fields = 0.

FSM states, with a single counter `cnt` cleared on every state entry:
- **IDLE**: idle word. `start` latches `mode` and the bases, then goes to WXMEM.
- **WXMEM**, `col`+1 cycles:
  - For `cnt`<`col`: CEN_xmem=0, WEN_xmem=1, A_xmem=`w_base`+`cnt`.
  - For `cnt`≥1: write strobe asserted. This is l0_wr in WS and ififo_wr in OS, covering the 1-cycle SRAM read latency.
- **WLOAD**, `col` cycles: load=1, plus l0_rd (WS) or ififo_rd (OS).
- **WFLUSH**, `row`+`col` cycles: idle word. Weights propagate through the array.
- **AXMEM**, `len_nij`+1 cycles: as WXMEM with `a_base`; always uses l0_wr.
- **EXEC**, `len_nij` cycles: execute=1, l0_rd=1.
- **DRAIN**, `row`+`col` cycles: idle word. The OFIFO fills.
- **PWR**, `len_nij` cycles: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=`p_base`+`cnt`. The pmem write uses the OFIFO head present in the same cycle.
- **DONE**, 1 cycle: `done`=1, then return to IDLE.

Rules:
- Bit 34 equals the latched mode in every non-IDLE state; it is 0 in IDLE.
- Address arithmetic is modulo 2^`xaw` / 2^`paw` (wrap-around permitted, no error).
- `start` while `busy` is ignored. `start` held high across DONE begins a new pass on the cycle after returning to IDLE.

## Timing
- Reset: asynchronous to IDLE. While reset is high and immediately after its release:
  - `inst` = 35'h1_800C_0000
  - `busy` = 0
  - `done` = 0
  - latched mode/bases = 0
- Reset mid-pass aborts with no further memory or FIFO strobes.
- `inst`, `busy` and `done` decode from state/counter/latch registers only; there is no combinational path from `start`.
- If `start` is sampled at edge E0, WXMEM is cycle 1. With defaults, `done` is high in cycle 159: 9+8+16+37+36+16+36 = 158 cycles, plus DONE.
- `busy` is high for cycles 1–159.

## Structure
- Package `corelet_inst_pkg` holds:
  - localparams for every inst bit position/field (reused by `core` decode and benches);
  - the idle-word constant;
  - the state enum encoding.
- One sub-module, `seq_counter`: loadable up-counter with terminal-count compare against a per-state limit. Everything else, including state transitions and inst encoding, stays in `corelet_seq`.

## Test plan
- **Reset value**: assert reset mid-EXEC (cycle 80) → `inst`=35'h1_800C_0000 asynchronously, `busy`=0; after release, IDLE holds until `start`.
- **WS pass**: defaults, `w_base`=0, `a_base`=11'd8, `p_base`=0, `mode`=0 → expected sequence:
  - A_xmem 0..7 with l0_wr in cycles 2–9;
  - load in cycles 10–17;
  - execute in cycles 71–106;
  - pmem writes to 0..35 in cycles 123–158;
  - `done` in cycle 159 only.
- **OS pass**: `mode`=1 → ififo_wr/ififo_rd replace l0_wr/l0_rd in the weight phases; inst[34]=1 in cycles 1–159; l0 strobes appear only in AXMEM/EXEC.
- **Address wrap**: `p_base`=11'h7F0 → A_pmem runs 7F0..7FF then 000..013.
- **Busy/start interaction**: `start` pulsed in cycle 50, and `start` held high continuously:
  - the cycle-50 pulse is ignored;
  - with `start` held high, the second pass's WXMEM begins 2 cycles after `done`.
